// File: rtl/pushsw_conditioner_if.sv
// Push-switch bundle: raw switch inputs in, debounced level / strobe / repeat-active out.
// Ports: PUSH (raw, async), LEVEL, PULSE, RPT_ACT; slave = conditioner side.
interface pushsw_conditioner_if #(
    parameter int N_SW = 2
);
    logic [N_SW-1:0] PUSH;
    logic [N_SW-1:0] LEVEL;
    logic [N_SW-1:0] PULSE;
    logic [N_SW-1:0] RPT_ACT;

    modport master (output PUSH, input LEVEL, input PULSE, input RPT_ACT);
    modport slave  (input PUSH, output LEVEL, output PULSE, output RPT_ACT);
endinterface

// File: rtl/pushsw_conditioner.sv
// Push-switch front end: per channel 2-FF sync, debounce, press strobe, auto-repeat.
// Ports: CLK, RSTn (async, active-low), sw (slave: PUSH in; LEVEL, PULSE, RPT_ACT out).
module pushsw_conditioner #(
    parameter int   N_SW       = 2,
    parameter logic PRESS_LVL  = 1'b1,
    parameter int   DB_CYCLES  = 250000,
    parameter int   RPT_EN     = 1,
    parameter int   RPT_DELAY  = 25000000,
    parameter int   RPT_PERIOD = 5000000
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    pushsw_conditioner_if.slave   sw
);
    localparam int DW   = $clog2(DB_CYCLES);
    localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(RPT_PERIOD - 1);

    typedef enum logic [1:0] {RELEASED, HOLD, REPEAT} state_t;

    logic [N_SW-1:0] sync1, sync2, pressed;
    logic [N_SW-1:0] level_q, level_d;
    logic [N_SW-1:0] pulse_q, pulse_d;
    logic [N_SW-1:0] act_q;
    logic [DW-1:0]   cnt_q [N_SW];
    logic [DW-1:0]   cnt_d [N_SW];
    logic [RW-1:0]   rc_q  [N_SW];
    logic [RW-1:0]   rc_d  [N_SW];
    state_t          state_q [N_SW];
    state_t          state_d [N_SW];

    // raw level is synchronised first; polarity is folded in afterwards
    assign pressed = sync2 ~^ {N_SW{PRESS_LVL}};

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_SW; i++) begin
            cnt_d[i] = '0;
            if (pressed[i] != level_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    level_d[i] = pressed[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // FSM looks at the next debounced level so that the press strobe
    // coincides with LEVEL rising and a release cancels a repeat at once
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < N_SW; i++) begin
            state_d[i] = state_q[i];
            rc_d[i]    = rc_q[i];
            unique case (state_q[i])
                RELEASED: begin
                    if (level_d[i]) begin
                        pulse_d[i] = 1'b1;
                        rc_d[i]    = '0;
                        state_d[i] = HOLD;
                    end
                end
                HOLD: begin
                    if (!level_d[i]) begin
                        state_d[i] = RELEASED;
                    end else if (RPT_EN != 0 && rc_q[i] == DLY_LAST) begin
                        pulse_d[i] = 1'b1;
                        rc_d[i]    = '0;
                        state_d[i] = REPEAT;
                    end else begin
                        rc_d[i] = rc_q[i] + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!level_d[i]) begin
                        state_d[i] = RELEASED;
                    end else if (rc_q[i] == PER_LAST) begin
                        pulse_d[i] = 1'b1;
                        rc_d[i]    = '0;
                    end else begin
                        rc_d[i] = rc_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = RELEASED;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1   <= {N_SW{~PRESS_LVL}};
            sync2   <= {N_SW{~PRESS_LVL}};
            level_q <= '0;
            pulse_q <= '0;
            act_q   <= '0;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i]   <= '0;
                rc_q[i]    <= '0;
                state_q[i] <= RELEASED;
            end
        end else begin
            sync1   <= sw.PUSH;
            sync2   <= sync1;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i]   <= cnt_d[i];
                rc_q[i]    <= rc_d[i];
                state_q[i] <= state_d[i];
                act_q[i]   <= (state_d[i] == REPEAT);
            end
        end
    end

    assign sw.LEVEL   = level_q;
    assign sw.PULSE   = pulse_q;
    assign sw.RPT_ACT = act_q;
endmodule

// File: tb/tb_pushsw_conditioner.sv
// Bench for pushsw_conditioner: repeat-enabled and repeat-disabled instances share stimulus.
// A run-length / press-time model is compared every cycle, plus literal timing pins.
module tb_pushsw_conditioner;
    localparam int DB = 4;
    localparam int D  = 10;
    localparam int P  = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] push = 2'b00;

    pushsw_conditioner_if #(.N_SW(2)) if_rep ();
    pushsw_conditioner_if #(.N_SW(2)) if_one ();

    assign if_rep.PUSH = push;
    assign if_one.PUSH = push;

    pushsw_conditioner #(
        .N_SW(2), .PRESS_LVL(1'b1), .DB_CYCLES(DB),
        .RPT_EN(1), .RPT_DELAY(D), .RPT_PERIOD(P)
    ) u_rep (.CLK(clk), .RSTn(rstn), .sw(if_rep));

    pushsw_conditioner #(
        .N_SW(2), .PRESS_LVL(1'b1), .DB_CYCLES(DB),
        .RPT_EN(0), .RPT_DELAY(D), .RPT_PERIOD(P)
    ) u_one (.CLK(clk), .RSTn(rstn), .sw(if_one));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tb_cyc = 0;

    // model state: ms1/ms2 sync pipe, run = consecutive cycles of disagreement
    bit ms1 [2], ms2 [2], mlvl [2];
    int run [2];
    bit held [2][2];
    int press [2][2];
    bit mpulse [2][2], mact [2][2];

    // observation logs (edge index of each strobe)
    int q_rep0 [$], q_rep1 [$], q_one0 [$], q_one1 [$];
    int act_rise0 = -1;
    bit prev_act0 = 1'b0;
    int any_hi = 0;
    int lvl_hi1 = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic int qat(input int q [$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    task automatic model_step();
        bit s, rose, fell;
        for (int i = 0; i < 2; i++) begin
            s = ms2[i];
            ms2[i] = ms1[i];
            ms1[i] = push[i];
            rose = 1'b0;
            fell = 1'b0;
            if (s != mlvl[i]) begin
                run[i]++;
                if (run[i] == DB) begin
                    mlvl[i] = s;
                    run[i] = 0;
                    rose = s;
                    fell = !s;
                end
            end else begin
                run[i] = 0;
            end
            for (int r = 0; r < 2; r++) begin
                mpulse[r][i] = 1'b0;
                if (rose) begin
                    held[r][i] = 1'b1;
                    press[r][i] = tb_cyc;
                    mpulse[r][i] = 1'b1;
                end else if (fell) begin
                    held[r][i] = 1'b0;
                end else if (held[r][i] && r == 1 && tb_cyc >= press[r][i] + D
                             && (tb_cyc - press[r][i] - D) % P == 0) begin
                    mpulse[r][i] = 1'b1;
                end
                mact[r][i] = held[r][i] && r == 1 && tb_cyc >= press[r][i] + D;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms1[i] = 1'b0;
            ms2[i] = 1'b0;
            mlvl[i] = 1'b0;
            run[i] = 0;
            for (int r = 0; r < 2; r++) begin
                held[r][i] = 1'b0;
                mpulse[r][i] = 1'b0;
                mact[r][i] = 1'b0;
            end
        end
    endtask

    always begin
        logic [5:0] exp_rep, exp_one, got_rep, got_one;
        @(posedge clk);
        #1;
        tb_cyc++;
        if (!rstn) model_reset();
        else model_step();
        exp_rep = {mlvl[1], mlvl[0], mpulse[1][1], mpulse[1][0], mact[1][1], mact[1][0]};
        exp_one = {mlvl[1], mlvl[0], mpulse[0][1], mpulse[0][0], mact[0][1], mact[0][0]};
        got_rep = {if_rep.LEVEL, if_rep.PULSE, if_rep.RPT_ACT};
        got_one = {if_one.LEVEL, if_one.PULSE, if_one.RPT_ACT};
        checks++;
        if (got_rep !== exp_rep) begin
            errors++;
            $display("FAIL cyc%0d rep {lvl,pls,act} got=%b exp=%b", tb_cyc, got_rep, exp_rep);
        end
        checks++;
        if (got_one !== exp_one) begin
            errors++;
            $display("FAIL cyc%0d one {lvl,pls,act} got=%b exp=%b", tb_cyc, got_one, exp_one);
        end
        if (if_rep.PULSE[0]) q_rep0.push_back(tb_cyc);
        if (if_rep.PULSE[1]) q_rep1.push_back(tb_cyc);
        if (if_one.PULSE[0]) q_one0.push_back(tb_cyc);
        if (if_one.PULSE[1]) q_one1.push_back(tb_cyc);
        if (if_rep.RPT_ACT[0] && !prev_act0 && act_rise0 < 0) act_rise0 = tb_cyc;
        prev_act0 = if_rep.RPT_ACT[0];
        if (got_rep != 6'd0 || got_one != 6'd0) any_hi++;
        if (if_rep.LEVEL[1]) lvl_hi1++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        q_rep0.delete();
        q_rep1.delete();
        q_one0.delete();
        q_one1.delete();
        act_rise0 = -1;
        any_hi = 0;
        lvl_hi1 = 0;
    endtask

    initial begin
        int t;
        tick(3);
        rstn = 1'b1;

        // idle after reset: nothing moves
        clear_logs();
        tick(50);
        chk("idle_any_high", any_hi, 0);

        // short bounce on channel 1
        clear_logs();
        push[1] = 1'b1;
        tick(3);
        push[1] = 1'b0;
        tick(15);
        chk("bounce_pulses", q_rep1.size(), 0);
        chk("bounce_level", lvl_hi1, 0);

        // clean press, 8 cycles; edge k = t+1, strobe at k+5
        clear_logs();
        t = tb_cyc;
        push[1] = 1'b1;
        tick(8);
        push[1] = 1'b0;
        tick(20);
        chk("press_count", q_rep1.size(), 1);
        chk("press_time", qat(q_rep1, 0), t + 6);
        chk("press_count_norpt", q_one1.size(), 1);

        // long hold on channel 0: p, p+10, p+13 ... until release
        clear_logs();
        t = tb_cyc;
        push[0] = 1'b1;
        tick(40);
        push[0] = 1'b0;
        tick(20);
        chk("hold_count", q_rep0.size(), 11);
        chk("hold_press", qat(q_rep0, 0), t + 6);
        chk("hold_rpt1", qat(q_rep0, 1), t + 16);
        chk("hold_rpt2", qat(q_rep0, 2), t + 19);
        chk("hold_act_rise", act_rise0, t + 16);
        chk("hold_count_norpt", q_one0.size(), 1);

        // both channels together, then reset mid-repeat
        clear_logs();
        t = tb_cyc;
        push = 2'b11;
        tick(20);
        chk("both_ch0", qat(q_rep0, 0), t + 6);
        chk("both_ch1", qat(q_rep1, 0), t + 6);
        chk("both_act", int'(if_rep.RPT_ACT), 3);
        rstn = 1'b0;
        #1;
        chk("rst_rep_out", int'({if_rep.LEVEL, if_rep.PULSE, if_rep.RPT_ACT}), 0);
        chk("rst_one_out", int'({if_one.LEVEL, if_one.PULSE, if_one.RPT_ACT}), 0);
        tick(2);
        clear_logs();
        rstn = 1'b1;
        t = tb_cyc;
        tick(10);
        chk("rst_repress0", qat(q_rep0, 0), t + 6);
        chk("rst_repress1", qat(q_one1, 0), t + 6);
        push = 2'b00;
        tick(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
